// File: rtl/rf_ctrl_pkg.sv
// Shared types and sizes for the register-file writeback controller.
// Address and data widths of the register file are fixed here.
package rf_ctrl_pkg;

  localparam int unsigned PW       = 4;
  localparam int unsigned DW       = 8;
  localparam int unsigned NUM_REGS = 2 ** PW;

  typedef enum logic {INIT, RUN} state_t;

  typedef enum logic {REQ_A, REQ_B} req_t;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Requester handshakes, register-file write port and hazard mask of rf_wb_ctrl.
interface rf_wb_ctrl_if;
  import rf_ctrl_pkg::*;

  logic                a_valid;
  logic                a_ready;
  logic [PW-1:0]       a_addr;
  logic [DW-1:0]       a_data;
  logic                b_valid;
  logic                b_ready;
  logic [PW-1:0]       b_addr;
  logic [DW-1:0]       b_data;
  logic                rf_wr_en;
  logic [PW:0]         rf_wr_addr;
  logic [DW-1:0]       rf_dat_in;
  logic                init_done;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_dat_in, init_done, pending
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_dat_in, init_done, pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Shift-style writeback FIFO: entry 0 is always the head, so every valid
// entry is exposed in place for the pending-write mask.
module wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic                        pop,
  input  wb_entry_t                   wr_entry,
  output wb_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [DEPTH-1:0]            vld,
  output logic [DEPTH-1:0][PW-1:0]    addrs
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[DEPTH-1] = 1'b0;
      cnt_d          = cnt_q - CW'(1);
    end
    // Push lands in the first free slot after any same-cycle pop.
    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CW'(i) == cnt_d) begin
          mem_d[i] = wr_entry;
          vld_d[i] = 1'b1;
        end
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      addrs[i] = mem_q[i].addr;
    end
  end

  assign head  = mem_q[0];
  assign count = cnt_q;
  assign vld   = vld_q;

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-port controller for the 16x8 register file: zero sweep after reset,
// then round-robin sharing of the write port between ALU (A) and load (B) FIFOs.
module rf_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic         clk,
  input logic         reset_n,
  rf_wb_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_t        state_q;
  logic [PW-1:0] init_cnt_q;
  logic          init_done_q;
  req_t          rr_q;

  wb_entry_t               a_head, b_head;
  logic [CW-1:0]           a_cnt, b_cnt;
  logic [DEPTH-1:0]        a_vld, b_vld;
  logic [DEPTH-1:0][PW-1:0] a_addrs, b_addrs;

  logic run, a_ready, b_ready, a_push, b_push, grant_a, grant_b;

  assign run     = (state_q == RUN);
  // Ready looks only at occupancy, keeping valid->ready free of combinational paths.
  assign a_ready = run && (a_cnt < CW'(DEPTH));
  assign b_ready = run && (b_cnt < CW'(DEPTH));
  assign a_push  = bus.a_valid && a_ready;
  assign b_push  = bus.b_valid && b_ready;

  assign grant_a = run && (a_cnt != '0) && ((b_cnt == '0) || (rr_q == REQ_A));
  assign grant_b = run && (b_cnt != '0) && !grant_a;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (a_push),
    .pop      (grant_a),
    .wr_entry ('{addr: bus.a_addr, data: bus.a_data}),
    .head     (a_head),
    .count    (a_cnt),
    .vld      (a_vld),
    .addrs    (a_addrs)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (b_push),
    .pop      (grant_b),
    .wr_entry ('{addr: bus.b_addr, data: bus.b_data}),
    .head     (b_head),
    .count    (b_cnt),
    .vld      (b_vld),
    .addrs    (b_addrs)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rr_q        <= REQ_A;
    end else if (state_q == INIT) begin
      if (init_cnt_q == PW'(NUM_REGS - 1)) begin
        state_q     <= RUN;
        init_done_q <= 1'b1;
      end else begin
        init_cnt_q <= init_cnt_q + PW'(1);
      end
    end else if (grant_a) begin
      rr_q <= REQ_B;
    end else if (grant_b) begin
      rr_q <= REQ_A;
    end
  end

  always_comb begin
    bus.rf_wr_en   = 1'b0;
    bus.rf_wr_addr = '0;
    bus.rf_dat_in  = '0;
    if (!run) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = {1'b0, init_cnt_q};
    end else if (grant_a) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = {1'b0, a_head.addr};
      bus.rf_dat_in  = a_head.data;
    end else if (grant_b) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = {1'b0, b_head.addr};
      bus.rf_dat_in  = b_head.data;
    end
  end

  always_comb begin
    bus.pending = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (a_vld[i]) bus.pending[a_addrs[i]] = 1'b1;
      if (b_vld[i]) bus.pending[b_addrs[i]] = 1'b1;
    end
  end

  assign bus.a_ready   = a_ready;
  assign bus.b_ready   = b_ready;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed and random writeback traffic checked each cycle
// against a queue-based model of the sweep, FIFOs and round-robin arbitration.
module tb_rf_wb_ctrl;
  import rf_ctrl_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  rf_wb_ctrl_if bus ();

  rf_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Register file as the DUT's write port would update it.
  logic [7:0] rf_mem [16];
  always @(posedge clk) begin
    if (bus.rf_wr_en === 1'b1) rf_mem[bus.rf_wr_addr[3:0]] <= bus.rf_dat_in;
  end

  // Reference model.
  bit         m_init;
  int         m_idx;
  bit         m_rr_b;
  logic [11:0] qa[$];
  logic [11:0] qb[$];
  logic [7:0] m_regs [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
  endtask

  // Called at a falling edge: check current outputs, drive inputs, advance model.
  task automatic step(input bit av, input logic [3:0] aa, input logic [7:0] ad,
                      input bit bv, input logic [3:0] ba, input logic [7:0] bd,
                      output bit acc_a, output bit acc_b);
    logic        e_en, e_ra, e_rb, e_done;
    logic [4:0]  e_addr;
    logic [7:0]  e_data;
    logic [15:0] e_pend;
    int          g;
    g = -1; e_en = 0; e_addr = '0; e_data = '0; e_pend = '0;
    if (m_init) begin
      e_en = 1; e_addr = {1'b0, 4'(m_idx)}; e_ra = 0; e_rb = 0; e_done = 0;
    end else begin
      e_ra   = (qa.size() < DEPTH);
      e_rb   = (qb.size() < DEPTH);
      e_done = 1;
      foreach (qa[i]) e_pend[qa[i][11:8]] = 1'b1;
      foreach (qb[i]) e_pend[qb[i][11:8]] = 1'b1;
      if (qa.size() > 0 && (qb.size() == 0 || !m_rr_b)) g = 0;
      else if (qb.size() > 0) g = 1;
      if (g == 0) begin e_en = 1; e_addr = {1'b0, qa[0][11:8]}; e_data = qa[0][7:0]; end
      if (g == 1) begin e_en = 1; e_addr = {1'b0, qb[0][11:8]}; e_data = qb[0][7:0]; end
    end
    chk("rf_wr_en",   32'(bus.rf_wr_en),   32'(e_en));
    chk("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(e_addr));
    chk("rf_dat_in",  32'(bus.rf_dat_in),  32'(e_data));
    chk("a_ready",    32'(bus.a_ready),    32'(e_ra));
    chk("b_ready",    32'(bus.b_ready),    32'(e_rb));
    chk("init_done",  32'(bus.init_done),  32'(e_done));
    chk("pending",    32'(bus.pending),    32'(e_pend));

    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    acc_a = 0; acc_b = 0;
    if (m_init) begin
      m_regs[m_idx] = 8'h00;
      if (m_idx == 15) m_init = 0;
      else m_idx++;
    end else begin
      if (g == 0) begin m_regs[qa[0][11:8]] = qa[0][7:0]; void'(qa.pop_front()); m_rr_b = 1; end
      if (g == 1) begin m_regs[qb[0][11:8]] = qb[0][7:0]; void'(qb.pop_front()); m_rr_b = 0; end
      if (av && e_ra) begin qa.push_back({aa, ad}); acc_a = 1; end
      if (bv && e_rb) begin qb.push_back({ba, bd}); acc_b = 1; end
    end
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    bit x, y;
    for (int i = 0; i < n; i++) step(0, 4'd0, 8'd0, 0, 4'd0, 8'd0, x, y);
  endtask

  // Asynchronous reset: outputs must take their reset values without a clock edge.
  task automatic apply_reset();
    reset_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_wr_en",     32'(bus.rf_wr_en),   32'd1);
    chk("rst_wr_addr",   32'(bus.rf_wr_addr), 32'd0);
    chk("rst_dat_in",    32'(bus.rf_dat_in),  32'd0);
    chk("rst_pending",   32'(bus.pending),    32'd0);
    chk("rst_a_ready",   32'(bus.a_ready),    32'd0);
    chk("rst_b_ready",   32'(bus.b_ready),    32'd0);
    chk("rst_init_done", 32'(bus.init_done),  32'd0);
    m_init = 1; m_idx = 0; m_rr_b = 0;
    qa.delete(); qb.delete();
    m_regs[0] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic sweep_with_noise();
    bit x, y;
    for (int i = 0; i < 16; i++) begin
      step(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom),
           8'($urandom), x, y);
    end
  endtask

  initial begin
    bit acc_a, acc_b, x, y;
    int na, nb;
    idle_inputs();
    #2;
    apply_reset();

    // Zero sweep, requests during INIT ignored; first RUN cycle shows init_done.
    sweep_with_noise();
    idle_steps(2);

    // Lone A write: visible next cycle, pending for one cycle.
    step(1, 4'd3, 8'h5A, 0, 4'd0, 8'd0, x, y);
    idle_steps(2);
    chk("reg3_value", 32'(rf_mem[3]), 32'h5A);

    // Lone B write leaves rr pointing at A.
    step(0, 4'd0, 8'd0, 1, 4'd4, 8'h44, x, y);
    idle_steps(2);

    // Both streaming every cycle.
    na = 0; nb = 0;
    for (int k = 0; k < 12; k++) begin
      step(1, 4'd1, 8'(8'h10 + na), 1, 4'd2, 8'(8'h20 + nb), acc_a, acc_b);
      na += int'(acc_a);
      nb += int'(acc_b);
    end
    idle_steps(5);

    // Same-register collision with rr at A: B's value must win.
    step(0, 4'd0, 8'd0, 1, 4'd5, 8'h55, x, y);
    idle_steps(2);
    step(1, 4'd7, 8'hAA, 1, 4'd7, 8'hBB, x, y);
    idle_steps(3);
    chk("reg7_value", 32'(rf_mem[7]), 32'hBB);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 4) != 0), 4'($urandom), 8'($urandom),
           1'($urandom_range(0, 4) != 0), 4'($urandom), 8'($urandom), x, y);
    end
    idle_steps(5);
    for (int r = 0; r < 16; r++) chk("regs_after_random", 32'(rf_mem[r]), 32'(m_regs[r]));

    // Reset in RUN with two entries queued: they are dropped, sweep restarts.
    step(1, 4'd9, 8'h99, 1, 4'd10, 8'hA0, x, y);
    apply_reset();
    sweep_with_noise();
    idle_steps(3);
    chk("reg9_dropped",  32'(rf_mem[9]),  32'h00);
    chk("reg10_dropped", 32'(rf_mem[10]), 32'h00);
    for (int r = 0; r < 16; r++) chk("regs_after_reset", 32'(rf_mem[r]), 32'(m_regs[r]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
